sort_block_loader: RTL and testbench
====================================

Name: sort_block_loader

Overview:
- Input-side loader for the sorting subsystem.
- Accepts a serial stream of 32-bit keys on a valid/ready interface and packs them into 512-bit blocks of 16 words.
- Presents the blocks one at a time, on a valid/ready handshake, to the sorting-network stage. A batch is 8 blocks (128 keys).
- Replaces the hard-coded 4096-bit preload, so batches can be streamed in from a host or DMA path.

Parameters:
- WORD_W, 32, key width in bits.
- WORDS_PER_BLK, 16, words packed into one block.
- BLKS_PER_BATCH, 8, blocks per sort batch.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  WORD_W  key word.
- in_last  in  1  marks the final word of a batch.
- blk_valid  out  1  blk_data holds a complete block.
- blk_ready  in  1  downstream takes the block this cycle.
- blk_data  out  WORD_W*WORDS_PER_BLK  packed block.
- blk_idx  out  3  index of the presented block within its batch, 0..7.
- blk_last  out  1  the presented block is the last block of the batch.
- batch_done  out  1  one-cycle pulse when the last block of a batch is accepted.
- err  out  1  sticky framing error.

Behaviour:
- Reset values: in_ready=1, blk_valid=0, blk_data=0, blk_idx=0, blk_last=0, batch_done=0, err=0. All counters are 0 and both buffers are empty.
- Word transfer: a word is taken when in_valid && in_ready.
- Block transfer: a block is taken when blk_valid && blk_ready.
- Packing order: the first accepted word goes in the MSB slot [511:480] and word 15 goes in [31:0]. Block 0 of a batch is the most-significant slice of the batch.
- Buffering: two-stage.
  - Fill register: collects words; word counter wcnt runs 0..15.
  - Output register: drives blk_data.
- Fill-to-output move: when the 16th word is accepted in cycle N, the fill register moves to the output register at the edge ending cycle N if the output register is empty, or is being consumed in cycle N. blk_valid then goes high in cycle N+1, so block latency from the last word is 1 cycle.
- Stall: if the fill register is full and the output register is held (blk_valid && !blk_ready), then in_ready=0 until the output drains.
  - in_ready is registered-state derived only: in_ready = !fill_full.
  - A pending full fill register moves in the same cycle the output is accepted.
- Zero-bubble rule: a continuous stream with blk_ready held at 1 sustains 1 word per cycle.
- Block counter bcnt:
  - Increments on each fill-to-output move.
  - blk_idx is the value of bcnt captured with the block.
  - blk_last = (blk_idx == BLKS_PER_BATCH-1).
  - Wraps to 0 after 7, so the next batch starts at block 0.
- batch_done pulses in the cycle after the handshake on the blk_last block.
- Framing (no pad build):
  - in_last asserted on any word other than the 128th of a batch sets err.
  - The 128th word without in_last also sets err.
  - Packing continues regardless; err clears only on rst.
- Stability: blk_data, blk_idx and blk_last are held stable while blk_valid && !blk_ready.
- Mid-operation reset: partial blocks and counters are discarded, and the block returns to the reset state immediately.

Optional Feature:
- Macro SORT_LOADER_PAD_EN.
- Defined: in_last on word k < 128 ends the batch early.
  - The remaining slots of the current block are filled with 32'hFFFFFFFF, the maximum key, so padding sorts to the tail.
  - Then all-ones blocks are generated until blk_idx 7 has been emitted.
  - in_ready=0 while padding; padding adds one cycle per generated block.
  - Early in_last does not set err.
- Undefined: the framing rules above apply and there is no padding logic.

Decomposition:
- Shared package sort_pkg holds:
  - WORD_W, WORDS_PER_BLK, BLKS_PER_BATCH;
  - BLK_W = WORD_W*WORDS_PER_BLK;
  - PAD_KEY = 32'hFFFFFFFF;
  - the block-index width constant.
- One natural sub-module: sort_word_packer, containing the fill register, wcnt and shift-in, with a "full" output.
- The top level contains the output register, bcnt, the handshakes and the pad FSM (IDLE/FILL/PAD).

Test Plan:
- Reset, then stream words 0..127 with blk_ready=1 -> 8 blocks with blk_idx 0..7.
  - Block 0 [511:480]=0 and [31:0]=15.
  - blk_last only on block 7, batch_done pulses once, in_ready never drops, err=0.
- Same stream with blk_ready=0 for 40 cycles after block 0 is presented -> in_ready drops after word 31.
  - blk_data is held stable, no word is lost, and resumed output matches the reference packing.
- 16th word accepted in cycle N -> blk_valid=1 in N+1 with correct blk_data.
- Without pad: in_last on word 50 -> err=1 and stays set; the 128th word without in_last also sets err.
- With SORT_LOADER_PAD_EN: 20 words then in_last -> block 1 slots 4..15 = FFFFFFFF.
  - Blocks 2..7 are all ones, batch_done pulses after block 7, err=0.
- Assert rst mid-block after 7 words, then send 128 fresh words -> first block contains only the new words 0..15, and blk_idx restarts at 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants and types for the sort batch loader.
//   WORD_W / WORDS_PER_BLK / BLKS_PER_BATCH : key, block and batch geometry
//   BLK_W    : packed block width
//   IDX_W    : block-index width, WCNT_W : word-counter width
//   PAD_KEY  : maximum key, used to pad short batches (SORT_LOADER_PAD_EN builds)
//   pad_state_e : states of the pad FSM
//   pad_tail()  : completes a partial fill register with PAD_KEY words
package sort_pkg;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_BLK  = 16;
  localparam int BLKS_PER_BATCH = 8;
  localparam int BLK_W          = WORD_W * WORDS_PER_BLK;
  localparam int IDX_W          = $clog2(BLKS_PER_BATCH);
  localparam int WCNT_W         = $clog2(WORDS_PER_BLK);
  localparam logic [WORD_W-1:0] PAD_KEY = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAD  = 2'd2
  } pad_state_e;

  // The wcnt most recent words sit in the low bits of the fill register.
  // Shift them to the top and fill every vacated slot with PAD_KEY; with
  // wcnt == 0 the result is an all-pad block.
  function automatic logic [BLK_W-1:0] pad_tail(input logic [BLK_W-1:0] fill,
                                                input logic [WCNT_W-1:0] wcnt);
    int unsigned sh;
    logic [BLK_W-1:0] keep_mask;
    sh        = WORD_W * (WORDS_PER_BLK - int'(wcnt));
    keep_mask = {BLK_W{1'b1}} << sh;
    return (fill << sh) | ({WORDS_PER_BLK{PAD_KEY}} & ~keep_mask);
  endfunction
endpackage

// File: rtl/sort_block_loader_if.sv
// Key-stream and block-stream handshake bundle of the sort batch loader.
//   in_valid/in_ready/in_data/in_last : serial key input
//   blk_valid/blk_ready/blk_data/blk_idx/blk_last : packed block output
//   batch_done : pulse after the last block of a batch is taken
//   err        : sticky framing error
// slave modport = loader view, master modport = host/sorter view.
interface sort_block_loader_if;
  import sort_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W-1:0]  blk_data;
  logic [IDX_W-1:0]  blk_idx;
  logic              blk_last;
  logic              batch_done;
  logic              err;

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_idx, blk_last, batch_done, err
  );

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_idx, blk_last, batch_done, err
  );
endinterface

// File: rtl/sort_word_packer.sv
// Fill register of the loader: shifts keys in, first key ending at the MSB.
//   shift_en/shift_data : accept one key this cycle
//   pad_en              : complete the current block with PAD_KEY words
//                         (port only present with SORT_LOADER_PAD_EN)
//   move_en             : the completed/pending block leaves this edge
//   next_blk/complete   : block completed in this cycle (combinational, so
//                         the top can move it on the same edge)
//   fill_data/full      : pending complete block that could not move yet
//   wcnt                : words held in the current block, 0..15
module sort_word_packer
  import sort_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] shift_data,
`ifdef SORT_LOADER_PAD_EN
  input  logic              pad_en,
`endif
  input  logic              move_en,
  output logic [BLK_W-1:0]  fill_data,
  output logic [BLK_W-1:0]  next_blk,
  output logic              complete,
  output logic [WCNT_W-1:0] wcnt,
  output logic              full
);
  logic [BLK_W-1:0]  fill_r;
  logic [WCNT_W-1:0] wcnt_r;
  logic              full_r;
  logic [BLK_W-1:0]  shifted_s;
  logic [BLK_W-1:0]  next_blk_s;
  logic              complete_s;

  // Shifted value and block-completion detection for this cycle.
  always_comb begin
    shifted_s  = {fill_r[BLK_W-WORD_W-1:0], shift_data};
    next_blk_s = shifted_s;
    complete_s = shift_en && (wcnt_r == WCNT_W'(WORDS_PER_BLK - 1));
`ifdef SORT_LOADER_PAD_EN
    if (pad_en) begin
      next_blk_s = pad_tail(fill_r, wcnt_r);
      complete_s = 1'b1;
    end else begin
      next_blk_s = shifted_s;
    end
`endif
  end

  // Fill register, word counter and pending-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_r <= {BLK_W{1'b0}};
      wcnt_r <= WCNT_W'(0);
      full_r <= 1'b0;
    end else if (complete_s) begin
      fill_r <= next_blk_s;
      wcnt_r <= WCNT_W'(0);
      full_r <= !move_en;
    end else if (shift_en) begin
      fill_r <= shifted_s;
      wcnt_r <= wcnt_r + WCNT_W'(1);
    end else if (move_en) begin
      full_r <= 1'b0;
    end
  end

  assign fill_data = fill_r;
  assign next_blk  = next_blk_s;
  assign complete  = complete_s;
  assign wcnt      = wcnt_r;
  assign full      = full_r;
endmodule

// File: rtl/sort_block_loader.sv
// Input-side loader of the sorting subsystem: packs 32-bit keys into 512-bit
// blocks (16 keys, first key in [511:480]) and presents 8 blocks per batch.
// Ports: clk, rst (async, active-high), bus (sort_block_loader_if.slave).
// Two-stage buffering: the packer's fill register feeds the output register;
// a completed block moves on the same edge whenever the output is free, so a
// continuous stream with blk_ready high runs at one key per cycle.
// Build option SORT_LOADER_PAD_EN: an early in_last pads the batch with
// all-ones keys up to block 7 instead of flagging a framing error.
module sort_block_loader
  import sort_pkg::*;
(
  input  logic clk,
  input  logic rst,
  sort_block_loader_if.slave bus
);
  logic [BLK_W-1:0]  fill_data_s;
  logic [BLK_W-1:0]  next_blk_s;
  logic [WCNT_W-1:0] wcnt_s;
  logic              complete_s;
  logic              full_s;
  logic              in_ready_s;
  logic              word_take_s;
  logic              out_free_s;
  logic              move_s;
  logic              is_last_pos_s;
  logic              frame_err_s;

  logic [BLK_W-1:0]  blk_data_r;
  logic [IDX_W-1:0]  blk_idx_r;
  logic              blk_last_r;
  logic              blk_valid_r;
  logic [IDX_W-1:0]  bcnt_r;
  logic              batch_done_r;
  logic              err_r;

`ifdef SORT_LOADER_PAD_EN
  pad_state_e state_r;
  pad_state_e state_s;
  logic       pad_go_s;
`endif

  // Handshake and move decisions. A pending full block blocks input, so
  // {bcnt, wcnt} is always the batch position of the word being accepted.
  always_comb begin
`ifdef SORT_LOADER_PAD_EN
    in_ready_s = !full_s && (state_r != ST_PAD);
`else
    in_ready_s = !full_s;
`endif
    word_take_s   = bus.in_valid && in_ready_s;
    out_free_s    = !blk_valid_r || bus.blk_ready;
    move_s        = out_free_s && (full_s || complete_s);
    is_last_pos_s = (bcnt_r == IDX_W'(BLKS_PER_BATCH - 1)) &&
                    (wcnt_s == WCNT_W'(WORDS_PER_BLK - 1));
  end

  // Framing check on each accepted word.
  always_comb begin
    frame_err_s = 1'b0;
    if (word_take_s) begin
`ifdef SORT_LOADER_PAD_EN
      frame_err_s = is_last_pos_s && !bus.in_last;
`else
      frame_err_s = (bus.in_last != is_last_pos_s);
`endif
    end else begin
      frame_err_s = 1'b0;
    end
  end

`ifdef SORT_LOADER_PAD_EN
  // Pad FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pad FSM next state: one pad block per cycle until block 7 has moved out.
  always_comb begin
    state_s  = state_r;
    pad_go_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FILL: begin
        if (word_take_s && bus.in_last && !is_last_pos_s) begin
          state_s = ST_PAD;
        end else if (word_take_s && is_last_pos_s) begin
          state_s = ST_IDLE;
        end else if (word_take_s) begin
          state_s = ST_FILL;
        end else begin
          state_s = state_r;
        end
      end
      ST_PAD: begin
        pad_go_s = !full_s;
        if (move_s && (bcnt_r == IDX_W'(BLKS_PER_BATCH - 1))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end
`endif

  sort_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (word_take_s),
    .shift_data(bus.in_data),
`ifdef SORT_LOADER_PAD_EN
    .pad_en    (pad_go_s),
`endif
    .move_en   (move_s),
    .fill_data (fill_data_s),
    .next_blk  (next_blk_s),
    .complete  (complete_s),
    .wcnt      (wcnt_s),
    .full      (full_s)
  );

  // Output register: load on a move, otherwise drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_data_r  <= {BLK_W{1'b0}};
      blk_idx_r   <= IDX_W'(0);
      blk_last_r  <= 1'b0;
      blk_valid_r <= 1'b0;
    end else if (move_s) begin
      blk_data_r  <= full_s ? fill_data_s : next_blk_s;
      blk_idx_r   <= bcnt_r;
      blk_last_r  <= (bcnt_r == IDX_W'(BLKS_PER_BATCH - 1));
      blk_valid_r <= 1'b1;
    end else if (bus.blk_ready) begin
      blk_valid_r <= 1'b0;
    end
  end

  // Block counter: one step per move, wraps so each batch starts at block 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_r <= IDX_W'(0);
    end else if (move_s) begin
      bcnt_r <= bcnt_r + IDX_W'(1);
    end
  end

  // Batch-done pulse (cycle after the last block is taken) and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batch_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      batch_done_r <= blk_valid_r && bus.blk_ready && blk_last_r;
      if (frame_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.blk_valid  = blk_valid_r;
  assign bus.blk_data   = blk_data_r;
  assign bus.blk_idx    = blk_idx_r;
  assign bus.blk_last   = blk_last_r;
  assign bus.batch_done = batch_done_r;
  assign bus.err        = err_r;
endmodule

// File: tb/tb_sort_block_loader.sv
// Directed bench for sort_block_loader. Keys are their own stream index, so
// block i of a full batch is expected to hold keys 16*i .. 16*i+15.
module tb_sort_block_loader;
  import sort_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  sort_block_loader_if bus();

  sort_block_loader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state (cleared while rst is high).
  logic [511:0] q_data[$];
  int           q_idx[$];
  bit           q_last[$];
  int           done_cnt = 0;
  int           low_cnt = 0;
  int           acc_cnt = 0;
  int           first_low = -1;
  int           t16 = -1;
  int           first_valid = -1;
  int           stab_viol = 0;
  bit           hold_prev = 1'b0;
  logic [511:0] data_prev = '0;
  logic [2:0]   idx_prev = '0;
  logic         last_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q_data.delete();
      q_idx.delete();
      q_last.delete();
      done_cnt    <= 0;
      low_cnt     <= 0;
      acc_cnt     <= 0;
      first_low   <= -1;
      t16         <= -1;
      first_valid <= -1;
      stab_viol   <= 0;
      hold_prev   <= 1'b0;
    end else begin
      if (bus.blk_valid && bus.blk_ready) begin
        q_data.push_back(bus.blk_data);
        q_idx.push_back(int'(bus.blk_idx));
        q_last.push_back(bus.blk_last);
      end
      if (bus.batch_done) done_cnt <= done_cnt + 1;
      if (!bus.in_ready) begin
        low_cnt <= low_cnt + 1;
        if (first_low < 0) first_low <= acc_cnt;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt <= acc_cnt + 1;
        if (acc_cnt == 15 && t16 < 0) t16 <= cyc;
      end
      if (bus.blk_valid && first_valid < 0) first_valid <= cyc;
      if (hold_prev && (bus.blk_data !== data_prev || bus.blk_idx !== idx_prev ||
                        bus.blk_last !== last_prev)) begin
        stab_viol <= stab_viol + 1;
      end
      hold_prev <= bus.blk_valid && !bus.blk_ready;
      data_prev <= bus.blk_data;
      idx_prev  <= bus.blk_idx;
      last_prev <= bus.blk_last;
    end
  end

  function automatic logic [511:0] ref_blk(input int base);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r = {r[479:0], 32'(base + k)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.blk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offer one key until accepted; returns 1 ns after the accepting edge.
  task automatic send(input int d, input bit l);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'(d);
    bus.in_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    check($sformatf("send_accept_%0d", d), 512'(acc), 512'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_batch(input int first, input int n, input bit last_on_end);
    for (int i = 0; i < n; i++) send(first + i, last_on_end && (i == n - 1));
  endtask

  task automatic wait_blocks(input int n);
    for (int t = 0; t < 400 && q_data.size() < n; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check("block_count", 512'(q_data.size()), 512'(n));
  endtask

  task automatic check_full_batch(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i < q_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), q_data[i], ref_blk(16 * i));
        check($sformatf("%s_idx%0d", tag, i), 512'(q_idx[i]), 512'(i));
        check($sformatf("%s_last%0d", tag, i), 512'(q_last[i]), 512'(i == 7));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   512'(bus.in_ready),   512'(1));
    check({tag, "_blk_valid"},  512'(bus.blk_valid),  512'(0));
    check({tag, "_blk_data"},   bus.blk_data,         512'(0));
    check({tag, "_blk_idx"},    512'(bus.blk_idx),    512'(0));
    check({tag, "_blk_last"},   512'(bus.blk_last),   512'(0));
    check({tag, "_batch_done"}, 512'(bus.batch_done), 512'(0));
    check({tag, "_err"},        512'(bus.err),        512'(0));
  endtask

  logic [511:0] exp_blk;
  logic [511:0] q0;

  initial begin
    // Reset state
    do_reset();
    check_reset_outputs("reset");

    // Full batch, blk_ready held high: zero bubbles, 1-cycle block latency
    send_batch(0, 128, 1'b1);
    wait_blocks(8);
    check_full_batch("stream");
    if (q_data.size() > 0) begin
      q0 = q_data[0];
      check("blk0_msb_word", 512'(q0[511:480]), 512'(0));
      check("blk0_lsb_word", 512'(q0[31:0]), 512'(15));
    end
    check("stream_latency", 512'(first_valid), 512'(t16 + 1));
    check("stream_batch_done", 512'(done_cnt), 512'(1));
    check("stream_in_ready_low", 512'(low_cnt), 512'(0));
    check("stream_err", 512'(bus.err), 512'(0));

    // Output held for 40 cycles after block 0 appears
    do_reset();
    bus.blk_ready = 1'b0;
    fork
      send_batch(0, 128, 1'b1);
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (bus.blk_valid) break;
        end
        repeat (40) @(posedge clk);
        #1 bus.blk_ready = 1'b1;
      end
    join
    wait_blocks(8);
    check_full_batch("stall");
    check("stall_first_low_after", 512'(first_low), 512'(32));
    check("stall_stability", 512'(stab_viol), 512'(0));
    check("stall_batch_done", 512'(done_cnt), 512'(1));
    check("stall_err", 512'(bus.err), 512'(0));

`ifdef SORT_LOADER_PAD_EN
    // Early in_last on the 20th key pads the rest of the batch
    do_reset();
    send_batch(0, 20, 1'b1);
    wait_blocks(8);
    if (q_data.size() == 8) begin
      check("pad_data0", q_data[0], ref_blk(0));
      exp_blk = {32'd16, 32'd17, 32'd18, 32'd19, {12{32'hFFFF_FFFF}}};
      check("pad_data1", q_data[1], exp_blk);
      for (int i = 2; i < 8; i++) begin
        check($sformatf("pad_data%0d", i), q_data[i], {16{32'hFFFF_FFFF}});
      end
      for (int i = 0; i < 8; i++) begin
        check($sformatf("pad_idx%0d", i), 512'(q_idx[i]), 512'(i));
      end
      check("pad_last7", 512'(q_last[7]), 512'(1));
    end
    check("pad_batch_done", 512'(done_cnt), 512'(1));
    check("pad_err", 512'(bus.err), 512'(0));
`else
    // Early in_last sets err, which stays set
    do_reset();
    send_batch(0, 50, 1'b0);
    check("err_before_early_last", 512'(bus.err), 512'(0));
    send(50, 1'b1);
    check("err_after_early_last", 512'(bus.err), 512'(1));
    send_batch(51, 77, 1'b0);
    check("err_sticky", 512'(bus.err), 512'(1));
    wait_blocks(8);
    check_full_batch("err_pack");

    // 128th key without in_last sets err
    do_reset();
    send_batch(0, 127, 1'b0);
    check("err_before_128th", 512'(bus.err), 512'(0));
    send(127, 1'b0);
    check("err_missing_last", 512'(bus.err), 512'(1));
    wait_blocks(8);
`endif

    // Reset mid-block, then a fresh batch
    do_reset();
    send_batch(900, 7, 1'b0);
    do_reset();
    check_reset_outputs("midreset");
    send_batch(0, 128, 1'b1);
    wait_blocks(8);
    check_full_batch("fresh");
    check("fresh_batch_done", 512'(done_cnt), 512'(1));
    check("fresh_err", 512'(bus.err), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
